// File: rtl/uart_arq_link.sv
// Serial link with a 32-bit framed transmitter and receiver (start, data LSB first, even parity,
// stop). A receive parity error raises a one-cycle retransmit request for the far-end transmitter.
module uart_arq_link #(
  parameter int unsigned size      = 32,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic            CLK_Baudin,
  input  logic            Rst,
  input  logic [size-1:0] DataIn,
  input  logic            NewData,
  input  logic            Flag_in,
  output logic            TransmittedSerialData,
  output logic            DoneTx,
  input  logic            SerialInputData,
  output logic [size-1:0] DataOut,
  output logic            DoneRx,
  output logic            Flag_Rx
);

  localparam int unsigned CW = (size > 1) ? $clog2(size) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxData, RxParity, RxStop} rx_state_e;

  tx_state_e       r_tx_state, w_tx_state;
  logic [size-1:0] r_tx_word, w_tx_word;
  logic [CW-1:0]   r_tx_cnt, w_tx_cnt;
  logic [RW-1:0]   r_retry, w_retry;
  logic            r_flag, w_flag;
  logic            r_line, w_line;
  logic            r_done_tx, w_done_tx;

  rx_state_e       r_rx_state, w_rx_state;
  logic [size-1:0] r_rx_shift, w_rx_shift;
  logic [CW-1:0]   r_rx_cnt, w_rx_cnt;
  logic            r_perr, w_perr;
  logic [size-1:0] r_data_out, w_data_out;
  logic            r_done_rx, w_done_rx;
  logic            r_flag_rx, w_flag_rx;

  // The line register always holds the bit being driven for the state just entered.
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_word  = r_tx_word;
    w_tx_cnt   = r_tx_cnt;
    w_retry    = r_retry;
    w_flag     = r_flag;
    w_line     = r_line;
    w_done_tx  = 1'b0;
    case (r_tx_state)
      TxIdle: begin
        w_line = 1'b1;
        if (NewData) begin
          w_tx_word  = DataIn;
          w_line     = 1'b0;
          w_tx_state = TxStart;
        end
      end
      TxStart: begin
        w_line     = r_tx_word[0];
        w_tx_cnt   = '0;
        w_tx_state = TxData;
      end
      TxData: begin
        if (r_tx_cnt == CW'(size - 1)) begin
          w_line     = ^r_tx_word;
          w_tx_state = TxParity;
        end else begin
          w_tx_cnt = r_tx_cnt + CW'(1);
          w_line   = r_tx_word[w_tx_cnt];
        end
      end
      TxParity: begin
        if (Flag_in) w_flag = 1'b1;
        w_line     = 1'b1;
        w_tx_state = TxStop;
      end
      TxStop: begin
        // A request arriving on the final edge still counts, so the latch is bypassed here.
        if ((r_flag || Flag_in) && (r_retry < RW'(MAX_RETRY))) begin
          w_retry    = r_retry + RW'(1);
          w_flag     = 1'b0;
          w_line     = 1'b0;
          w_tx_state = TxStart;
        end else begin
          w_retry    = '0;
          w_flag     = 1'b0;
          w_line     = 1'b1;
          w_done_tx  = 1'b1;
          w_tx_state = TxIdle;
        end
      end
      default: begin
        w_line     = 1'b1;
        w_tx_state = TxIdle;
      end
    endcase
  end

  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_shift = r_rx_shift;
    w_rx_cnt   = r_rx_cnt;
    w_perr     = r_perr;
    w_data_out = r_data_out;
    w_done_rx  = 1'b0;
    w_flag_rx  = 1'b0;
    case (r_rx_state)
      RxIdle: begin
        if (!SerialInputData) begin
          w_rx_cnt   = '0;
          w_rx_state = RxData;
        end
      end
      RxData: begin
        w_rx_shift = {SerialInputData, r_rx_shift[size-1:1]};
        if (r_rx_cnt == CW'(size - 1)) w_rx_state = RxParity;
        else                           w_rx_cnt   = r_rx_cnt + CW'(1);
      end
      RxParity: begin
        w_perr     = SerialInputData ^ (^r_rx_shift);
        w_flag_rx  = w_perr;
        w_rx_state = RxStop;
      end
      RxStop: begin
        if (SerialInputData && !r_perr) begin
          w_data_out = r_rx_shift;
          w_done_rx  = 1'b1;
        end
        w_rx_state = RxIdle;
      end
      default: w_rx_state = RxIdle;
    endcase
  end

  always_ff @(posedge CLK_Baudin) begin
    if (Rst) begin
      r_tx_state <= TxIdle;
      r_tx_word  <= '0;
      r_tx_cnt   <= '0;
      r_retry    <= '0;
      r_flag     <= 1'b0;
      r_line     <= 1'b1;
      r_done_tx  <= 1'b0;
      r_rx_state <= RxIdle;
      r_rx_shift <= '0;
      r_rx_cnt   <= '0;
      r_perr     <= 1'b0;
      r_data_out <= '0;
      r_done_rx  <= 1'b0;
      r_flag_rx  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_word  <= w_tx_word;
      r_tx_cnt   <= w_tx_cnt;
      r_retry    <= w_retry;
      r_flag     <= w_flag;
      r_line     <= w_line;
      r_done_tx  <= w_done_tx;
      r_rx_state <= w_rx_state;
      r_rx_shift <= w_rx_shift;
      r_rx_cnt   <= w_rx_cnt;
      r_perr     <= w_perr;
      r_data_out <= w_data_out;
      r_done_rx  <= w_done_rx;
      r_flag_rx  <= w_flag_rx;
    end
  end

  assign TransmittedSerialData = r_line;
  assign DoneTx                = r_done_tx;
  assign DataOut               = r_data_out;
  assign DoneRx                = r_done_rx;
  assign Flag_Rx               = r_flag_rx;

endmodule

// File: tb/tb_uart_arq_link.sv
// Directed loopback bench: Tx drives Rx, Flag_Rx feeds Flag_in, with bit-flip, stop-kill and
// forced-flag hooks on the loop.
module tb_uart_arq_link;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        new_data;
  logic        flag_force;
  logic        flip;
  logic        kill;
  logic        line;
  logic        done_tx;
  logic [31:0] data_out;
  logic        done_rx;
  logic        flag_rx;
  logic        rx_in;
  logic        flag_in;

  int n_checks = 0;
  int n_errors = 0;
  int n_dtx = 0;
  int n_drx = 0;
  int n_flg = 0;
  int s_dtx, s_drx, s_flg;

  assign rx_in   = (line ^ flip) & ~kill;
  assign flag_in = flag_rx | flag_force;

  uart_arq_link #(.size(32), .MAX_RETRY(3)) dut (
    .CLK_Baudin           (clk),
    .Rst                  (rst),
    .DataIn               (data_in),
    .NewData              (new_data),
    .Flag_in              (flag_in),
    .TransmittedSerialData(line),
    .DoneTx               (done_tx),
    .SerialInputData      (rx_in),
    .DataOut              (data_out),
    .DoneRx               (done_rx),
    .Flag_Rx              (flag_rx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_tx) n_dtx++;
    if (done_rx) n_drx++;
    if (flag_rx) n_flg++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_dtx = n_dtx;
    s_drx = n_drx;
    s_flg = n_flg;
  endtask

  // Entered just after E0 (start bit on the line); returns just after E34 (stop bit on the line).
  task automatic frame_body(input logic [31:0] w, input logic par, input int flip_idx,
                            input int req_idx);
    chk("start_bit", 32'(line), 32'd0);
    for (int i = 0; i < 32; i++) begin
      step();
      flip = (i == flip_idx);
      if (i == req_idx) begin
        new_data = 1'b1;
        data_in  = ~w;
      end else begin
        new_data = 1'b0;
      end
      chk("data_bit", 32'(line), 32'(w[i]));
    end
    flip     = 1'b0;
    new_data = 1'b0;
    step();
    chk("parity_bit", 32'(line), 32'(par));
    step();
    chk("stop_bit", 32'(line), 32'd1);
    chk("no_done_tx_in_frame", 32'(n_dtx - s_dtx), 32'd0);
  endtask

  task automatic send_clean(input logic [31:0] w, input logic par);
    data_in  = w;
    new_data = 1'b1;
    snap();
    step();
    new_data = 1'b0;
    frame_body(w, par, -1, -1);
    step();
    chk("done_tx", 32'(done_tx), 32'd1);
    chk("done_rx", 32'(done_rx), 32'd1);
    chk("data_out", data_out, w);
    chk("no_flag_rx", 32'(n_flg - s_flg), 32'd0);
    step();
    chk("done_tx_one_cycle", 32'(done_tx), 32'd0);
    chk("done_rx_one_cycle", 32'(done_rx), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    data_in    = '0;
    new_data   = 1'b0;
    flag_force = 1'b0;
    flip       = 1'b0;
    kill       = 1'b0;
    step();
    step();
    step();
    chk("rst_line", 32'(line), 32'd1);
    chk("rst_done_tx", 32'(done_tx), 32'd0);
    chk("rst_done_rx", 32'(done_rx), 32'd0);
    chk("rst_flag_rx", 32'(flag_rx), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_line", 32'(line), 32'd1);

    // Clean loopback words, parity 0, 0, 1.
    send_clean(32'hA5A5_A5A5, 1'b0);
    send_clean(32'hDEAD_BEEF, 1'b0);
    send_clean(32'h1234_5678, 1'b1);

    // Corrupt d5 of the first frame only: Flag_Rx during stop, silent resend.
    data_in  = 32'h1234_5678;
    new_data = 1'b1;
    snap();
    step();
    new_data = 1'b0;
    frame_body(32'h1234_5678, 1'b1, 5, -1);
    chk("flag_rx_on_stop", 32'(flag_rx), 32'd1);
    step();
    chk("retry_no_done_tx", 32'(done_tx), 32'd0);
    chk("retry_no_done_rx", 32'(done_rx), 32'd0);
    chk("retry_data_out_held", data_out, 32'h1234_5678);
    frame_body(32'h1234_5678, 1'b1, -1, -1);
    step();
    chk("resend_done_tx", 32'(done_tx), 32'd1);
    chk("resend_done_rx", 32'(done_rx), 32'd1);
    chk("resend_data_out", data_out, 32'h1234_5678);
    chk("resend_one_flag", 32'(n_flg - s_flg), 32'd1);
    chk("resend_one_done_tx", 32'(n_dtx - s_dtx + 32'(done_tx)), 32'd1);
    step();

    // Permanent retransmit request: 1 + MAX_RETRY frames, then one DoneTx.
    flag_force = 1'b1;
    data_in    = 32'hCAFE_F00D;
    new_data   = 1'b1;
    snap();
    step();
    new_data = 1'b0;
    for (int f = 0; f < 4; f++) begin
      frame_body(32'hCAFE_F00D, 1'b0, -1, -1);
      step();
      chk("forced_done_rx", 32'(done_rx), 32'd1);
      chk("forced_done_tx", 32'(done_tx), (f == 3) ? 32'd1 : 32'd0);
      chk("forced_line", 32'(line), (f == 3) ? 32'd1 : 32'd0);
    end
    flag_force = 1'b0;
    step();
    step();
    chk("forced_idle_line", 32'(line), 32'd1);
    chk("forced_single_done_tx", 32'(n_dtx - s_dtx), 32'd1);
    chk("forced_four_done_rx", 32'(n_drx - s_drx), 32'd4);

    // NewData with different data mid-frame is ignored.
    data_in  = 32'h0F0F_1234;
    new_data = 1'b1;
    snap();
    step();
    new_data = 1'b0;
    frame_body(32'h0F0F_1234, 1'b1, -1, 10);
    step();
    chk("busy_done_tx", 32'(done_tx), 32'd1);
    chk("busy_data_out", data_out, 32'h0F0F_1234);
    step();
    chk("busy_no_restart", 32'(line), 32'd1);

    // Stop bit forced low at Rx: frame dropped silently.
    data_in  = 32'h55AA_00FF;
    new_data = 1'b1;
    snap();
    step();
    new_data = 1'b0;
    frame_body(32'h55AA_00FF, 1'b0, -1, -1);
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("frame_err_done_tx", 32'(done_tx), 32'd1);
    chk("frame_err_no_done_rx", 32'(done_rx), 32'd0);
    chk("frame_err_data_out", data_out, 32'h0F0F_1234);
    chk("frame_err_no_flag", 32'(n_flg - s_flg), 32'd0);
    step();

    // Reset mid-frame aborts both paths without pulses.
    data_in  = 32'h1357_9BDF;
    new_data = 1'b1;
    snap();
    step();
    new_data = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_line", 32'(line), 32'd1);
    chk("midrst_data_out", data_out, 32'd0);
    for (int i = 0; i < 40; i++) step();
    chk("midrst_idle_line", 32'(line), 32'd1);
    chk("midrst_no_done_tx", 32'(n_dtx - s_dtx), 32'd0);
    chk("midrst_no_done_rx", 32'(n_drx - s_drx), 32'd0);
    chk("midrst_no_flag", 32'(n_flg - s_flg), 32'd0);
    send_clean(32'h1357_9BDF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_arq_link.md
Name: uart_arq_link

Overview:
- Single-clock serial link block with one transmitter path and one receiver path.
- Transmitter sends 32-bit words as one-bit-per-clock frames: start, 32 data bits LSB first, even parity, stop.
- Receiver deserialises the same frame format, checks parity and stop, and raises a retransmit-request flag on a parity error.
- The Tx retransmit input is normally wired to the far end's flag, so a corrupted word is resent automatically. The block sits at the baud-clock boundary between a word-level producer/consumer and the serial line.

Parameters:
- size, 32, data word width in bits.
- MAX_RETRY, 3, maximum consecutive retransmissions of one word before Tx gives up.

Ports:
- CLK_Baudin  in  1  baud clock; one serial bit per rising edge.
- Rst  in  1  synchronous, active-high reset for both Tx and Rx.
- DataIn  in  size  word to transmit; sampled when a start is accepted.
- NewData  in  1  start request; honoured only when Tx is idle.
- Flag_in  in  1  retransmit request from the receiving end.
- TransmittedSerialData  out  1  serial line out; idles high.
- DoneTx  out  1  one-cycle pulse when a word is finished (delivered or abandoned).
- SerialInputData  in  1  serial line in.
- DataOut  out  size  last good received word.
- DoneRx  out  1  one-cycle pulse when DataOut is updated.
- Flag_Rx  out  1  one-cycle pulse on a receive parity error (retransmit request).

Behaviour:
- Reset (sampled on a CLK_Baudin edge), with reset values:
  - TransmittedSerialData=1; DoneTx=0; DoneRx=0; Flag_Rx=0; DataOut=0.
  - Both FSMs go to IDLE, retry count=0, flag latch cleared.
  - Reset mid-frame aborts the frame immediately, with no Done or Flag pulse.
- Tx FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- Tx edge E0, IDLE with NewData=1: latch DataIn; line=0 (start bit) for the cycle after E0.
- Tx edges E1..E32: line=DataIn[0]..DataIn[31].
- Tx edge E33: line=parity, where parity is the XOR of all 32 data bits (even parity).
- Tx edge E34: line=1 (stop bit).
- Tx retransmit latch: Flag_in sampled high at any edge while in PARITY or STOP sets the latch.
- Tx end of frame, at E35:
  - Latch set and retries < MAX_RETRY: retry+1, clear latch, line=0, i.e. the same latched word restarts at START. No DoneTx.
  - Otherwise: line=1, DoneTx=1 for one cycle, retry=0, return to IDLE.
- Tx while busy: NewData and DataIn changes are ignored. NewData is accepted again at the edge after DoneTx.
- Rx FSM states: IDLE, DATA, PARITY, STOP.
- Rx start detection: in IDLE, a 0 sampled on SerialInputData starts a frame. There is no oversampling.
- Rx sampling: the next 32 edges shift data in LSB first. The next edge samples parity, the next samples stop.
- Rx parity check, at the parity-sampling edge: if the received parity differs from the XOR of the received data, Flag_Rx=1 for the following cycle. That cycle coincides with the remote stop bit in a loopback, so Tx catches it.
- Rx stop-sampling edge:
  - Stop=1 and parity OK: DataOut=the received word, DoneRx=1 for one cycle.
  - Parity error: DataOut unchanged, no DoneRx.
  - Stop=0 (framing error): frame dropped, DataOut unchanged, no DoneRx, no Flag_Rx.
  - In all cases return to IDLE. A start bit can be detected on the very next edge.
- Loopback latency: NewData edge E0 gives DoneRx and DataOut valid after E35; DoneTx is high in the same cycle.
- DoneTx, DoneRx and Flag_Rx are never high for more than one consecutive cycle per event.

Test Plan:
- Reset, then Tx looped to Rx with Flag_Rx wired to Flag_in; NewData pulse with DataIn=0xA5A5A5A5 -> line 0, then bits LSB first, parity 0, stop 1; DoneTx and DoneRx both pulse 35 edges after acceptance; DataOut=0xA5A5A5A5; Flag_Rx never high.
- Loopback sends 0xDEADBEEF (parity 0) and then 0x12345678 (parity 1) -> parity bit on the line is 0 then 1; DataOut matches each word; no retransmits.
- Inject a bit flip on the data path for d5 of 0x12345678 on the first frame only -> Flag_Rx pulses during the stop bit; Tx resends without DoneTx; second frame is clean, giving DoneRx with DataOut=0x12345678 and one DoneTx.
- Hold Flag_in=1 permanently -> exactly 1+MAX_RETRY=4 frames are sent, then a single DoneTx; Tx returns to IDLE.
- Assert NewData mid-frame with different DataIn -> ignored; the current word completes unchanged.
- Force the stop bit to 0 on Rx -> no DoneRx, no Flag_Rx, DataOut holds. Assert Rst mid-frame -> line=1, no Done pulses, and the next NewData works normally.
